demux_m: RTL and testbench

//  Registered 1-to-2 stream demultiplexer: the routing counterpart of mux_m.

---
 rtl/demux_m_if.sv | 29 ++
 rtl/demux_m.sv | 86 ++++++++
 tb/tb_demux_m.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_m_if.sv
// Stream bundle for the 1-to-2 demultiplexer: one input port, two output
// ports and the per-output delivery counters.
interface demux_m_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] data_in;
    logic             sel_a;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_a;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] data_b;
    logic             b_valid;
    logic             b_ready;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    modport master (
        output data_in, sel_a, in_valid, a_ready, b_ready,
        input  in_ready, data_a, a_valid, data_b, b_valid, cnt_a, cnt_b
    );

    modport slave (
        input  data_in, sel_a, in_valid, a_ready, b_ready,
        output in_ready, data_a, a_valid, data_b, b_valid, cnt_a, cnt_b
    );
endinterface

// File: rtl/demux_m.sv
// Registered 1-to-2 stream demultiplexer with a one-entry holding register
// per output and per-output delivered-word counters.
module demux_m #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic     clk,
    input logic     rst,
    demux_m_if.slave bus
);
    logic [WIDTH-1:0] data_a_q;
    logic [WIDTH-1:0] data_b_q;
    logic             a_valid_q;
    logic             b_valid_q;
    logic [CNT_W-1:0] cnt_a_q;
    logic [CNT_W-1:0] cnt_b_q;

    logic a_take;
    logic b_take;
    logic a_free;
    logic b_free;
    logic in_rdy;
    logic in_xfer;
    logic load_a;
    logic load_b;

    assign a_take = a_valid_q & bus.a_ready;
    assign b_take = b_valid_q & bus.b_ready;

    // A slot is free if empty or being drained this cycle.
    assign a_free = ~a_valid_q | bus.a_ready;
    assign b_free = ~b_valid_q | bus.b_ready;

    assign in_rdy  = bus.sel_a ? a_free : b_free;
    assign in_xfer = bus.in_valid & in_rdy;
    assign load_a  = in_xfer & bus.sel_a;
    assign load_b  = in_xfer & ~bus.sel_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_a_q  <= '0;
            a_valid_q <= 1'b0;
        end else if (load_a) begin
            data_a_q  <= bus.data_in;
            a_valid_q <= 1'b1;
        end else if (a_take) begin
            a_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_b_q  <= '0;
            b_valid_q <= 1'b0;
        end else if (load_b) begin
            data_b_q  <= bus.data_in;
            b_valid_q <= 1'b1;
        end else if (b_take) begin
            b_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a_q <= '0;
        end else if (a_take) begin
            cnt_a_q <= cnt_a_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_b_q <= '0;
        end else if (b_take) begin
            cnt_b_q <= cnt_b_q + 1'b1;
        end
    end

    assign bus.in_ready = in_rdy;
    assign bus.data_a   = data_a_q;
    assign bus.a_valid  = a_valid_q;
    assign bus.data_b   = data_b_q;
    assign bus.b_valid  = b_valid_q;
    assign bus.cnt_a    = cnt_a_q;
    assign bus.cnt_b    = cnt_b_q;
endmodule

// File: tb/tb_demux_m.sv
// Directed and scoreboarded checks for the 1-to-2 stream demultiplexer.
module tb_demux_m;
    logic clk;
    logic rst;

    int n_checks;
    int n_err;

    demux_m_if #(.WIDTH(8), .CNT_W(8)) bus ();

    demux_m #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    initial begin
        logic [7:0] pd;
        logic       ps;
        logic       pend;
        logic       exp_rdy;
        int         sent;
        int         cyc;
        int         dlv_a;
        int         dlv_b;

        n_checks = 0;
        n_err    = 0;
        rst          = 1'b1;
        bus.data_in  = '0;
        bus.sel_a    = 1'b0;
        bus.in_valid = 1'b0;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        tick();
        tick();
        check("rst_a_valid", 32'(bus.a_valid), 0);
        check("rst_b_valid", 32'(bus.b_valid), 0);
        check("rst_data_a", 32'(bus.data_a), 0);
        check("rst_data_b", 32'(bus.data_b), 0);
        check("rst_cnt_a", 32'(bus.cnt_a), 0);
        check("rst_cnt_b", 32'(bus.cnt_b), 0);
        rst = 1'b0;
        tick();

        // route A5 to A and deliver it
        bus.data_in  = 8'hA5;
        bus.sel_a    = 1'b1;
        bus.in_valid = 1'b1;
        bus.a_ready  = 1'b1;
        #1;
        check("route_in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check("route_data_a", 32'(bus.data_a), 'hA5);
        check("route_a_valid", 32'(bus.a_valid), 1);
        check("route_cnt_a0", 32'(bus.cnt_a), 0);
        check("route_b_valid", 32'(bus.b_valid), 0);
        tick();
        check("route_cnt_a1", 32'(bus.cnt_a), 1);
        check("route_a_empty", 32'(bus.a_valid), 0);
        check("route_b_valid2", 32'(bus.b_valid), 0);

        // backpressure on A, B still accepts
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        bus.data_in  = 8'h3C;
        bus.sel_a    = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("bp_in_ready_empty", 32'(bus.in_ready), 1);
        tick();
        bus.data_in = 8'h99;
        #1;
        check("bp_in_ready_full", 32'(bus.in_ready), 0);
        tick();
        check("bp_data_a_held", 32'(bus.data_a), 'h3C);
        check("bp_a_valid_held", 32'(bus.a_valid), 1);
        bus.sel_a   = 1'b0;
        bus.data_in = 8'h0F;
        #1;
        check("bp_in_ready_b", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_data_b", 32'(bus.data_b), 'h0F);
        check("bp_b_valid", 32'(bus.b_valid), 1);
        check("bp_data_a_still", 32'(bus.data_a), 'h3C);
        check("bp_cnt_a", 32'(bus.cnt_a), 1);
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        tick();
        check("bp_drain_cnt_a", 32'(bus.cnt_a), 2);
        check("bp_drain_cnt_b", 32'(bus.cnt_b), 1);
        check("bp_drain_a_valid", 32'(bus.a_valid), 0);
        check("bp_drain_b_valid", 32'(bus.b_valid), 0);

        // drain and load in the same cycle
        bus.a_ready  = 1'b0;
        bus.data_in  = 8'h11;
        bus.sel_a    = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("dl_data_a_11", 32'(bus.data_a), 'h11);
        bus.a_ready  = 1'b1;
        bus.data_in  = 8'h22;
        bus.in_valid = 1'b1;
        #1;
        check("dl_in_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        bus.a_ready  = 1'b0;
        check("dl_a_valid", 32'(bus.a_valid), 1);
        check("dl_data_a_22", 32'(bus.data_a), 'h22);
        check("dl_cnt_a", 32'(bus.cnt_a), 3);

        // asynchronous reset with a word buffered
        rst = 1'b1;
        #1;
        check("arst_a_valid", 32'(bus.a_valid), 0);
        check("arst_data_a", 32'(bus.data_a), 0);
        check("arst_cnt_a", 32'(bus.cnt_a), 0);
        check("arst_cnt_b", 32'(bus.cnt_b), 0);
        tick();
        rst = 1'b0;

        // 16-word alternating stream at full rate
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.sel_a    = (i % 2 == 0);
            bus.data_in  = 8'(8'h40 + i);
            bus.in_valid = 1'b1;
            #1;
            check("str_in_ready", 32'(bus.in_ready), 1);
            tick();
            if (i % 2 == 0) begin
                check("str_data_a", 32'(bus.data_a), 32'('h40 + i));
                check("str_a_valid", 32'(bus.a_valid), 1);
            end else begin
                check("str_data_b", 32'(bus.data_b), 32'('h40 + i));
                check("str_b_valid", 32'(bus.b_valid), 1);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        check("str_cnt_a", 32'(bus.cnt_a), 8);
        check("str_cnt_b", 32'(bus.cnt_b), 8);

        // counter wrap on B
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.sel_a    = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.data_in = 8'(i);
            tick();
        end
        check("wrap_cnt_b_255", 32'(bus.cnt_b), 255);
        bus.in_valid = 1'b0;
        tick();
        check("wrap_cnt_b_0", 32'(bus.cnt_b), 0);
        check("wrap_b_valid", 32'(bus.b_valid), 0);
        check("wrap_cnt_a", 32'(bus.cnt_a), 0);

        // random handshakes against a scoreboard
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sent  = 0;
        cyc   = 0;
        dlv_a = 0;
        dlv_b = 0;
        pend  = 1'b0;
        pd    = '0;
        ps    = 1'b0;
        while ((sent < 1000 || qa.size() != 0 || qb.size() != 0)
               && cyc < 20000) begin
            if (!pend && sent < 1000) begin
                pd   = 8'($urandom);
                ps   = 1'($urandom_range(0, 1));
                pend = 1'b1;
            end
            bus.data_in  = pd;
            bus.sel_a    = ps;
            bus.in_valid = pend && ($urandom_range(0, 9) < 7);
            bus.a_ready  = ($urandom_range(0, 9) < 6);
            bus.b_ready  = ($urandom_range(0, 9) < 6);
            #1;
            exp_rdy = ps ? (qa.size() == 0 || bus.a_ready)
                         : (qb.size() == 0 || bus.b_ready);
            check("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            check("rnd_a_valid", 32'(bus.a_valid), 32'(qa.size() != 0));
            check("rnd_b_valid", 32'(bus.b_valid), 32'(qb.size() != 0));
            if (qa.size() != 0 && bus.a_ready) begin
                check("rnd_data_a", 32'(bus.data_a), 32'(qa.pop_front()));
                dlv_a++;
            end
            if (qb.size() != 0 && bus.b_ready) begin
                check("rnd_data_b", 32'(bus.data_b), 32'(qb.pop_front()));
                dlv_b++;
            end
            if (bus.in_valid && exp_rdy) begin
                if (ps) qa.push_back(pd);
                else    qb.push_back(pd);
                sent++;
                pend = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("rnd_timeout", 32'(cyc < 20000), 1);
        check("rnd_sent", 32'(sent), 1000);
        check("rnd_delivered", 32'(dlv_a + dlv_b), 1000);
        check("rnd_cnt_a", 32'(bus.cnt_a), 32'(dlv_a % 256));
        check("rnd_cnt_b", 32'(bus.cnt_b), 32'(dlv_b % 256));
        check("rnd_a_empty", 32'(bus.a_valid), 0);
        check("rnd_b_empty", 32'(bus.b_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end
endmodule
